// File: rtl/cpuc_out_capture.sv
// rtl/cpuc_out_capture.sv - timestamped change capture of the CPUC result buses into a drainable FIFO
// A change on {out1,out2} is queued with the timestamp of its sampling edge; overflow drops are counted.
module cpuc_out_capture #(
  parameter int W     = 16,
  parameter int DEPTH = 8,
  parameter int TSW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [W-1:0]             out1,
  input  logic [W-1:0]             out2,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [W-1:0]             rd_out1,
  output logic [W-1:0]             rd_out2,
  output logic [TSW-1:0]           rd_time,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]   mem1 [DEPTH];
  logic [W-1:0]   mem2 [DEPTH];
  logic [TSW-1:0] memt [DEPTH];

  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [TSW-1:0] ts;
  logic [2*W-1:0] last_pair;
  logic [2*W-1:0] pair;
  logic           prime;
  logic [W-1:0]   last1, last2;
  logic [TSW-1:0] lastt;
  logic           push_req, push_ok, pop, full, drop;

  assign pair     = {out1, out2};
  assign rd_valid = (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  assign push_req = en && (prime || (pair != last_pair));
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  // Once the FIFO drains, the head keeps showing the entry that was read last.
  assign rd_out1 = rd_valid ? mem1[rd_ptr] : last1;
  assign rd_out2 = rd_valid ? mem2[rd_ptr] : last2;
  assign rd_time = rd_valid ? memt[rd_ptr] : lastt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts        <= '0;
      last_pair <= '0;
      prime     <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
      last1     <= '0;
      last2     <= '0;
      lastt     <= '0;
    end else begin
      ts <= ts + 1'b1;
      // The pair is remembered even when its push is dropped, so one value drops only once.
      if (en) begin
        if (push_req) begin
          last_pair <= pair;
          prime     <= 1'b0;
        end
      end else begin
        prime <= 1'b1;
      end
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last1  <= mem1[rd_ptr];
        last2  <= mem2[rd_ptr];
        lastt  <= memt[rd_ptr];
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem1[wr_ptr] <= out1;
      mem2[wr_ptr] <= out2;
      memt[wr_ptr] <= ts;
    end
  end
endmodule

// File: tb/tb_cpuc_out_capture.sv
// tb/tb_cpuc_out_capture.sv - directed and random checks of cpuc_out_capture against a queue model
module tb_cpuc_out_capture;
  localparam int W = 16, DEPTH = 8, TSW = 16;

  logic          clk = 1'b0;
  logic          rst, en, rd_ready;
  logic [W-1:0]  out1, out2;
  logic          rd_valid, overflow;
  logic [W-1:0]  rd_out1, rd_out2;
  logic [TSW-1:0] rd_time;
  logic [3:0]    count;
  logic [7:0]    drop_cnt;

  cpuc_out_capture #(.W(W), .DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk(clk), .rst(rst), .en(en), .out1(out1), .out2(out2),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_out1(rd_out1), .rd_out2(rd_out2),
    .rd_time(rd_time), .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   o1;
    logic [W-1:0]   o2;
    logic [TSW-1:0] t;
  } ent_t;

  ent_t            q[$];
  ent_t            lr;
  logic [TSW-1:0]  ts_m;
  logic [2*W-1:0]  last_m;
  bit              prime_m, ovf_m;
  int              drops_m;
  int              total = 0, passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    lr      = '{o1: '0, o2: '0, t: '0};
    ts_m    = '0;
    last_m  = '0;
    prime_m = 1'b1;
    ovf_m   = 1'b0;
    drops_m = 0;
  endtask

  task automatic compare();
    ent_t h;
    h = (q.size() != 0) ? q[0] : lr;
    chk("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
    chk("count", 64'(count), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(ovf_m));
    chk("drop_cnt", 64'(drop_cnt), 64'(drops_m));
    chk("rd_out1", 64'(rd_out1), 64'(h.o1));
    chk("rd_out2", 64'(rd_out2), 64'(h.o2));
    chk("rd_time", 64'(rd_time), 64'(h.t));
  endtask

  // Predict one clock edge from the current inputs, then clock and compare.
  task automatic tick();
    int sz;
    bit pop, preq, acc;
    logic [2*W-1:0] pair;
    sz   = q.size();
    pop  = (sz > 0) && rd_ready;
    pair = {out1, out2};
    preq = en && (prime_m || (pair != last_m));
    if (en) begin
      if (preq) begin
        last_m  = pair;
        prime_m = 1'b0;
      end
    end else begin
      prime_m = 1'b1;
    end
    acc = preq && ((sz < DEPTH) || pop);
    if (pop) lr = q.pop_front();
    if (acc) q.push_back('{o1: out1, o2: out2, t: ts_m});
    else if (preq) begin
      ovf_m = 1'b1;
      if (drops_m != 255) drops_m++;
    end
    ts_m = ts_m + 1'b1;
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rd_ready = 1'b0; out1 = '0; out2 = '0;
    model_reset();
    @(posedge clk); #1;
    compare();
    @(posedge clk); #1;
    rst = 1'b0;

    // Constant zero bus: only the primed sample is captured.
    en = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    chk("prime_only_count", 64'(count), 64'd1);

    // Stepping bus read back as it arrives.
    rd_ready = 1'b1;
    tick();
    foreach (q[i]) ;
    out1 = 16'd5; tick();
    out1 = 16'd7; tick();
    out1 = 16'd7; tick();
    out1 = 16'd9; tick();
    tick(); tick();
    chk("step_drained", 64'(count), 64'd0);
    chk("step_last_read", 64'(rd_out1), 64'd9);

    // Ten distinct values into an eight-deep FIFO.
    rd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      out1 = 16'(100 + i);
      tick();
    end
    chk("fill_count", 64'(count), 64'd8);
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_drops", 64'(drop_cnt), 64'd2);

    // Full FIFO with a pop and a new change in the same cycle.
    rd_ready = 1'b1; out1 = 16'd200;
    tick();
    chk("full_pop_push_count", 64'(count), 64'd8);
    chk("full_pop_push_drops", 64'(drop_cnt), 64'd2);
    for (int i = 0; i < 9; i++) tick();
    chk("drain_empty", 64'(rd_valid), 64'd0);

    // Asynchronous reset with five entries queued.
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      out1 = 16'(300 + i);
      tick();
    end
    chk("pre_reset_count", 64'(count), 64'd5);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rd_valid", 64'(rd_valid), 64'd0);
    chk("async_count", 64'(count), 64'd0);
    chk("async_overflow", 64'(overflow), 64'd0);
    chk("async_rd_out1", 64'(rd_out1), 64'd0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("ts_restart", 64'(rd_time), 64'd0);

    // Enable toggle on a constant bus recaptures it.
    out1 = 16'd3; out2 = 16'd4; rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    en = 1'b1; rd_ready = 1'b0;
    tick();
    chk("reenable_capture", 64'(count), 64'd1);
    chk("reenable_out2", 64'(rd_out2), 64'd4);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      out1     = 16'($urandom_range(0, 3));
      out2     = 16'($urandom_range(0, 1));
      rd_ready = 1'($urandom_range(0, 1));
      tick();
    end

    // Drop counter saturation.
    en = 1'b1; rd_ready = 1'b0;
    for (int i = 0; i < 270; i++) begin
      out1 = 16'(1000 + i);
      tick();
    end
    chk("drop_saturate", 64'(drop_cnt), 64'd255);
    chk("overflow_sticky", 64'(overflow), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
